mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, memory address width (32 words).
REQ-002 The block SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 The block SHALL have ports `clk  in  1  sole clock`, with all state updated on its rising edge.
REQ-004 The block SHALL have port `rst  in  1  reset`; reset is asynchronous and active-high.
REQ-005 The block SHALL have ports `reqN_valid  in  1  request present`, for N in {0,1}.
REQ-006 The block SHALL have ports `reqN_we  in  1  1=write, 0=read`.
REQ-007 The block SHALL have ports `reqN_addr  in  ADDR_W  word address`.
REQ-008 The block SHALL have ports `reqN_wdata  in  DATA_W  write data`.
REQ-009 The block SHALL have ports `reqN_ready  out  1  request accepted this cycle`.
REQ-010 The block SHALL have ports `rspN_valid  out  1  one-cycle response strobe`.
REQ-011 The block SHALL have ports `rspN_rdata  out  DATA_W  response data`.
REQ-012 The block SHALL have port `mem_we  out  1` driving the single-port memory write enable.
REQ-013 The block SHALL have ports `mem_addr  out  ADDR_W` and `mem_din  out  DATA_W` driving the memory.
REQ-014 The block SHALL have port `mem_dout  in  DATA_W`, the memory's combinational read data.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP, with IDLE->ACCESS on handshake, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 A handshake SHALL occur only in IDLE and only for the granted requester: reqN_ready = (state==IDLE) && grant==N && reqN_valid.
REQ-017 Arbitration SHALL be round-robin:
- only one requester valid: that requester is granted;
- both valid: the requester not served last is granted;
- pointer after reset favours requester 0.
REQ-018 The last-served pointer SHALL update only on a handshake.
REQ-019 On handshake, the block SHALL latch we, addr, wdata and the requester id.
REQ-020 In ACCESS, mem_addr and mem_din SHALL carry the latched values, and mem_we SHALL equal the latched we; mem_we SHALL be 0 in every other state.
REQ-021 mem_addr and mem_din SHALL hold the latched values in all states.
REQ-022 At the ACCESS->RESP edge, the block SHALL capture mem_dout into the response register, so writes return the pre-write word.
REQ-023 In RESP, exactly the latched requester's rspN_valid SHALL be 1 for one cycle, with rspN_rdata equal to the captured word.
REQ-024 rspN_rdata SHALL hold its value until the next capture.
REQ-025 Latency SHALL be: handshake edge N, memory write/read capture at edge N+1, rsp_valid high between edges N+1 and N+2; throughput is one access per 3 cycles.
REQ-026 The block SHALL require that requesters keep valid and payload stable until ready; a request dropped before ready is ignored without side effects.
REQ-027 A requester asserting valid in the RESP cycle SHALL be considered in the following IDLE cycle.
REQ-028 A request to the same address as a write in flight SHALL observe the written data.

Reset
REQ-029 While rst=1, the block SHALL force state=IDLE, pointer to favour requester 0, mem_we=0, rsp0_valid=rsp1_valid=0, reqN_ready=0, all latches and rspN_rdata to 0.
REQ-030 An rst asserted during ACCESS SHALL drop mem_we immediately, so no write occurs at the next edge; the pending response SHALL be discarded.
REQ-031 Reset SHALL NOT alter memory contents.

Structure
REQ-032 A shared package SHALL hold the ADDR_W/DATA_W defaults, the FSM state enum (IDLE/ACCESS/RESP), and the requester-id typedef.
REQ-033 The round-robin grant logic SHALL be one sub-module, rr_arb2 (2 requests, pointer, grant out, update strobe).
REQ-034 The Memory instance SHALL be external to this block and connected at top level.

Verification
REQ-035 Read: mem[3]=8'hA5, req0 read addr 3 -> ready at cycle 0, rsp0_valid at cycle 2 with 8'hA5, rsp1_valid=0.
REQ-036 Write then read: req1 write addr 7 data 8'h3C -> rsp1_rdata = old mem[7]; then req0 read addr 7 -> 8'h3C.
REQ-037 Contention: both valid continuously after reset -> grants alternate 0,1,0,1 over 4 transactions, one handshake every 3 cycles.
REQ-038 Single requester: req1 alone valid for 3 transactions -> all granted to 1, no idle gaps beyond the 3-cycle cadence.
REQ-039 Reset mid-write: assert rst during ACCESS of write addr 2 data 8'hFF -> mem[2] unchanged, rsp valids 0, next request served from IDLE with grant 0.
REQ-040 Held request: req0 valid while req1 is in RESP -> req0 ready in the next IDLE cycle, payload stable, correct data returned.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Holds the FSM state encoding and the requester-id type.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-served pointer.
// The pointer only moves when the caller reports a handshake.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output req_id_t    o_grant
);

    req_id_t r_last;
    req_id_t w_grant;

    // Reset value 1 means requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= w_grant;
        end
    end

    always_comb begin
        w_grant = ~r_last;
        case (i_req)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            default: w_grant = ~r_last;
        endcase
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one external single-port memory.
// Each access takes IDLE -> ACCESS -> RESP, one access per 3 cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    req_id_t           r_id;

    req_id_t           w_grant;
    logic              w_sel_valid;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_hs;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({req1_valid, req0_valid}),
        .i_update (w_hs),
        .o_grant  (w_grant)
    );

    assign w_sel_valid = w_grant ? req1_valid : req0_valid;
    assign w_sel_we    = w_grant ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;

    assign w_hs = (r_state == IDLE) && w_sel_valid && !rst;

    assign req0_ready = w_hs && (w_grant == 1'b0);
    assign req1_ready = w_hs && (w_grant == 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_id    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_id    <= w_grant;
            end
            // Sampled before the write lands, so writes return the old word.
            if (r_state == ACCESS) begin
                r_rdata <= mem_dout;
            end
        end
    end

    // rst gates the strobes combinationally so a write never reaches the edge.
    always_comb begin
        w_state_nxt = r_state;
        mem_we      = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hs) w_state_nxt = ACCESS;
            end
            ACCESS: begin
                w_state_nxt = RESP;
                mem_we      = r_we && !rst;
            end
            RESP: begin
                w_state_nxt = IDLE;
                rsp0_valid  = !r_id && !rst;
                rsp1_valid  = r_id && !rst;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_addr   = r_addr;
    assign mem_din    = r_wdata;
    assign rsp0_rdata = r_rdata;
    assign rsp1_rdata = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, scoreboard monitor,
// a directed vector table and multi-cycle corner-case sequences.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] mem     [32];
    logic [DW-1:0] ref_mem [32];

    typedef struct packed {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    txn_t sb [$];
    int   hs_id [$];
    int   hs_cyc [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic m_last;
    vec_t vt [8];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end
    endtask

    // Scoreboard: push at handshake, pop and compare at the response strobe.
    always @(negedge clk) begin
        txn_t          t;
        logic [DW-1:0] e;
        if (rst) begin
            sb.delete();
            m_last = 1'b1;
        end else begin
            if (req0_ready || req1_ready) begin
                chk("ready_onehot", int'(req0_ready) + int'(req1_ready), 1);
                t.id = req1_ready;
                if (req0_valid && req1_valid)
                    chk("rr_grant", int'(t.id), int'(!m_last));
                m_last  = t.id;
                t.we    = t.id ? req1_we    : req0_we;
                t.addr  = t.id ? req1_addr  : req0_addr;
                t.wdata = t.id ? req1_wdata : req0_wdata;
                sb.push_back(t);
                hs_id.push_back(int'(t.id));
                hs_cyc.push_back(cyc);
            end
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_onehot", int'(rsp0_valid) + int'(rsp1_valid), 1);
                chk("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    t = sb.pop_front();
                    e = ref_mem[t.addr];
                    if (t.we) ref_mem[t.addr] = t.wdata;
                    chk("sb_id", int'(rsp1_valid), int'(t.id));
                    chk("sb_data", int'(rsp1_valid ? rsp1_rdata : rsp0_rdata), int'(e));
                end
            end
        end
    end

    task automatic do_req(input vec_t v, input string nm);
        int   n;
        logic got;
        @(posedge clk); #1;
        set_req(v.id, 1'b1, v.we, v.addr, v.wdata);
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            got = v.id ? req1_ready : req0_ready;
        end
        chk({nm, "_rdy_lat"}, n, 1);
        @(posedge clk); #1;
        set_req(v.id, 1'b0, 1'b0, '0, '0);
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            got = v.id ? rsp1_valid : rsp0_valid;
        end
        chk({nm, "_rsp_lat"}, n, 2);
        chk({nm, "_data"}, int'(v.id ? rsp1_rdata : rsp0_rdata), int'(v.exp));
        chk({nm, "_other"}, int'(v.id ? rsp0_valid : rsp1_valid), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk); n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic run_stream(input int want, input string nm);
        int n;
        n = 0;
        while (hs_id.size() < want && n < 40) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        chk({nm, "_count"}, int'(hs_id.size() >= want), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 5'd9, 8'h11);
        set_req(1'b1, 1'b1, 1'b1, 5'd9, 8'h22);
        for (int i = 0; i < 32; i++) begin
            mem[i]     <= 8'h40 + 8'(i);
            ref_mem[i]  = 8'h40 + 8'(i);
        end
        mem[3]     <= 8'hA5;
        ref_mem[3]  = 8'hA5;

        vt[0] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'hA5};
        vt[1] = '{1'b1, 1'b1, 5'd7,  8'h3C, 8'h47};
        vt[2] = '{1'b0, 1'b0, 5'd7,  8'h00, 8'h3C};
        vt[3] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h40};
        vt[4] = '{1'b0, 1'b1, 5'd31, 8'hE1, 8'h5F};
        vt[5] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'hE1};
        vt[6] = '{1'b1, 1'b1, 5'd0,  8'h00, 8'h40};
        vt[7] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00};

        @(negedge clk);
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_rsp0", int'(rsp0_valid), 0);
        chk("rst_rsp1", int'(rsp1_valid), 0);
        chk("rst_rdata", int'(rsp0_rdata), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_din", int'(mem_din), 0);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) do_req(vt[i], $sformatf("vec%0d", i));

        do_reset();
        chk("rst_keeps_mem", int'(mem[7]), 8'h3C);
        hs_id.delete(); hs_cyc.delete();
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 5'd3, '0);
        set_req(1'b1, 1'b1, 1'b0, 5'd7, '0);
        run_stream(4, "cont");
        if (hs_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("cont_id%0d", i), hs_id[i], i % 2);
            for (int i = 0; i < 3; i++)
                chk($sformatf("cont_gap%0d", i), hs_cyc[i+1] - hs_cyc[i], 3);
        end
        drain();

        hs_id.delete(); hs_cyc.delete();
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 5'd0, '0);
        run_stream(3, "single");
        if (hs_id.size() >= 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("single_id%0d", i), hs_id[i], 1);
            for (int i = 0; i < 2; i++)
                chk($sformatf("single_gap%0d", i), hs_cyc[i+1] - hs_cyc[i], 3);
        end
        drain();

        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 5'd7, '0);
        n = 0;
        while (!req1_ready && n < 10) begin @(negedge clk); n++; end
        chk("held_r1_ready", int'(req1_ready), 1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 5'd7, '0);
        @(negedge clk);
        chk("held_rsp1", int'(rsp1_valid), 1);
        chk("held_rdy_in_resp", int'(req0_ready), 0);
        @(negedge clk);
        chk("held_rdy_idle", int'(req0_ready), 1);
        chk("held_addr_stable", int'(req0_addr), 7);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("held_rsp0", int'(rsp0_valid), 1);
        chk("held_data", int'(rsp0_rdata), 8'h3C);

        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b1, 5'd2, 8'hFF);
        n = 0;
        while (!req1_ready && n < 10) begin @(negedge clk); n++; end
        chk("rmw_ready", int'(req1_ready), 1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rmw_access_we", int'(mem_we), 1);
        rst = 1'b1;
        #1 chk("rmw_we_drop", int'(mem_we), 0);
        set_req(1'b0, 1'b1, 1'b0, 5'd2, '0);
        set_req(1'b1, 1'b1, 1'b0, 5'd5, '0);
        @(negedge clk);
        chk("rmw_rdy0", int'(req0_ready), 0);
        chk("rmw_rdy1", int'(req1_ready), 0);
        chk("rmw_rsp0", int'(rsp0_valid), 0);
        chk("rmw_rsp1", int'(rsp1_valid), 0);
        @(posedge clk); #1;
        chk("rmw_mem2", int'(mem[2]), 8'h42);
        @(negedge clk);
        chk("rmw_rsp1b", int'(rsp1_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rmw_grant0", int'(req0_ready), 1);
        chk("rmw_no_grant1", int'(req1_ready), 0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rmw_rsp0_after", int'(rsp0_valid), 1);
        chk("rmw_data_after", int'(rsp0_rdata), 8'h42);
        chk("rmw_mem2_final", int'(mem[2]), 8'h42);

        drain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
